// File: rtl/mm_control_param.sv
// mm_control_param: address/control sequencer for a ROWS x COLS matrix-vector
// multiply P = A*x through one MAC with MAC_LAT cycles of pipeline latency.
// Issues one (row, col) element per unstalled cycle, then drains the result
// pipeline so the final write to P completes before done is pulsed.
module mm_control_param #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int ADDR_W  = 4,
  parameter int MAC_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Start,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              issue,
  output logic              control,
  output logic [ADDR_W-1:0] addr_A,
  output logic [ADDR_W-1:0] addr_x,
  output logic              result_en,
  output logic [ADDR_W-1:0] addr_P
);

  localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t             state;
  logic [ROW_W-1:0]   row;
  logic [COL_W-1:0]   col;
  logic [ADDR_W-1:0]  lin;

  logic               issue_now;
  logic               last_col;
  logic               last_row;
  logic               last_elem;
  logic               pipe_empty;

  logic [MAC_LAT-1:0] pipe_valid;
  logic [ROW_W-1:0]   pipe_row [MAC_LAT];

  // An element goes out on the Start edge itself (so it shows up in the first
  // busy cycle) and on every unstalled edge while running.
  always_comb begin
    issue_now = 1'b0;
    if (!stall) begin
      issue_now = (state == S_RUN) || ((state == S_IDLE) && Start);
    end
  end

  assign last_col   = (col == COL_W'(COLS - 1));
  assign last_row   = (row == ROW_W'(ROWS - 1));
  assign last_elem  = last_col && last_row;
  assign pipe_empty = ~|pipe_valid;

  // Control FSM, element counters and registered issue-side outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= S_IDLE;
      row     <= '0;
      col     <= '0;
      lin     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      issue   <= 1'b0;
      control <= 1'b0;
      addr_A  <= '0;
      addr_x  <= '0;
    end else begin
      issue <= issue_now;
      done  <= 1'b0;

      if (issue_now) begin
        addr_A  <= lin;
        addr_x  <= ADDR_W'(col);
        control <= (col == '0);
        lin     <= last_elem ? '0 : lin + ADDR_W'(1);
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + ROW_W'(1);
        end else begin
          col <= col + COL_W'(1);
        end
      end

      case (state)
        S_IDLE: begin
          if (Start) begin
            busy  <= 1'b1;
            state <= (issue_now && last_elem) ? S_DRAIN : S_RUN;
          end
        end
        S_RUN: begin
          if (issue_now && last_elem) begin
            state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (pipe_empty) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state   <= S_IDLE;
          busy    <= 1'b0;
          control <= 1'b0;
          addr_A  <= '0;
          addr_x  <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Result pipeline: tracks which issued element closes a row and emits the
  // P write strobe MAC_LAT cycles after that element was issued.
  always_ff @(posedge clk) begin
    if (!rst) begin
      pipe_valid <= '0;
      for (int i = 0; i < MAC_LAT; i++) begin
        pipe_row[i] <= '0;
      end
      result_en <= 1'b0;
      addr_P    <= '0;
    end else begin
      for (int i = MAC_LAT - 1; i > 0; i--) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_row[i]   <= pipe_row[i-1];
      end
      pipe_valid[0] <= issue_now && last_col;
      pipe_row[0]   <= row;
      result_en     <= pipe_valid[MAC_LAT-1];
      addr_P        <= pipe_valid[MAC_LAT-1] ? ADDR_W'(pipe_row[MAC_LAT-1]) : '0;
    end
  end

endmodule

// File: tb/tb_mm_control_param.sv
// tb_mm_control_param: directed bench for mm_control_param with three
// parameter sets sharing one stimulus stream. Cycle n is the cycle after the
// n-th rising edge following the cycle in which Start is first driven (cycle 0);
// an input driven during cycle n is seen by the design at the edge that opens cycle n+1.
module tb_mm_control_param;

  localparam int N = 64;

  logic clk = 1'b0;
  logic rst, start, stall;

  logic busy0, done0, issue0, control0, res0;
  logic [3:0] a0, x0, p0;
  logic busy1, done1, issue1, control1, res1;
  logic [3:0] a1, x1, p1;
  logic busy2, done2, issue2, control2, res2;
  logic [3:0] a2, x2, p2;

  int checks = 0;
  int failures = 0;

  logic st_start [N];
  logic st_stall [N];
  logic st_rst [N];

  logic       c_issue [3][N];
  logic       c_ctl [3][N];
  logic       c_busy [3][N];
  logic       c_done [3][N];
  logic       c_res [3][N];
  logic [3:0] c_a [3][N];
  logic [3:0] c_x [3][N];
  logic [3:0] c_p [3][N];

  always #5 clk = ~clk;

  mm_control_param #(.ROWS(4), .COLS(4), .ADDR_W(4), .MAC_LAT(2)) dut0 (
    .clk(clk), .rst(rst), .Start(start), .stall(stall),
    .busy(busy0), .done(done0), .issue(issue0), .control(control0),
    .addr_A(a0), .addr_x(x0), .result_en(res0), .addr_P(p0)
  );

  mm_control_param #(.ROWS(3), .COLS(1), .ADDR_W(4), .MAC_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .Start(start), .stall(stall),
    .busy(busy1), .done(done1), .issue(issue1), .control(control1),
    .addr_A(a1), .addr_x(x1), .result_en(res1), .addr_P(p1)
  );

  mm_control_param #(.ROWS(2), .COLS(5), .ADDR_W(4), .MAC_LAT(4)) dut2 (
    .clk(clk), .rst(rst), .Start(start), .stall(stall),
    .busy(busy2), .done(done2), .issue(issue2), .control(control2),
    .addr_A(a2), .addr_x(x2), .result_en(res2), .addr_P(p2)
  );

  task automatic clear_stim();
    for (int i = 0; i < N; i++) begin
      st_start[i] = 1'b0;
      st_stall[i] = 1'b0;
      st_rst[i]   = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run_capture(input int n);
    for (int c = 0; c <= n; c++) begin
      @(negedge clk);
      c_issue[0][c] = issue0; c_ctl[0][c] = control0; c_busy[0][c] = busy0;
      c_done[0][c] = done0; c_res[0][c] = res0;
      c_a[0][c] = a0; c_x[0][c] = x0; c_p[0][c] = p0;
      c_issue[1][c] = issue1; c_ctl[1][c] = control1; c_busy[1][c] = busy1;
      c_done[1][c] = done1; c_res[1][c] = res1;
      c_a[1][c] = a1; c_x[1][c] = x1; c_p[1][c] = p1;
      c_issue[2][c] = issue2; c_ctl[2][c] = control2; c_busy[2][c] = busy2;
      c_done[2][c] = done2; c_res[2][c] = res2;
      c_a[2][c] = a2; c_x[2][c] = x2; c_p[2][c] = p2;
      start = st_start[c];
      stall = st_stall[c];
      rst   = st_rst[c];
    end
    start = 1'b0;
    stall = 1'b0;
    rst   = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++; if ({busy0, done0, issue0, control0} !== 4'b0000) begin
      failures++; $display("[TB] FAIL reset_ctrl got=%b exp=0000", {busy0, done0, issue0, control0});
    end
    checks++; if ({a0, x0} !== 8'h00) begin
      failures++; $display("[TB] FAIL reset_addr got=%h exp=00", {a0, x0});
    end
    checks++; if ({res0, p0} !== 5'h00) begin
      failures++; $display("[TB] FAIL reset_result got=%h exp=00", {res0, p0});
    end
    checks++; if ({busy1, issue1, res1, busy2, issue2, res2} !== 6'b0) begin
      failures++; $display("[TB] FAIL reset_others got=%b exp=000000",
                           {busy1, issue1, res1, busy2, issue2, res2});
    end
  endtask

  task automatic test_basic();
    logic e_issue, e_busy, e_done, e_res;
    logic [3:0] e_p;
    do_reset();
    clear_stim();
    st_start[0] = 1'b1;
    run_capture(24);
    for (int c = 1; c <= 24; c++) begin
      e_issue = (c <= 16);
      e_busy  = (c <= 19);
      e_done  = (c == 19);
      e_res   = (c == 6) || (c == 10) || (c == 14) || (c == 18);
      e_p     = e_res ? 4'((c - 6) / 4) : 4'd0;
      checks++; if (c_issue[0][c] !== e_issue) begin
        failures++; $display("[TB] FAIL basic_issue c=%0d got=%b exp=%b", c, c_issue[0][c], e_issue);
      end
      checks++; if (c_busy[0][c] !== e_busy) begin
        failures++; $display("[TB] FAIL basic_busy c=%0d got=%b exp=%b", c, c_busy[0][c], e_busy);
      end
      checks++; if (c_done[0][c] !== e_done) begin
        failures++; $display("[TB] FAIL basic_done c=%0d got=%b exp=%b", c, c_done[0][c], e_done);
      end
      checks++; if (c_res[0][c] !== e_res || c_p[0][c] !== e_p) begin
        failures++; $display("[TB] FAIL basic_result c=%0d got=%b/%0d exp=%b/%0d",
                             c, c_res[0][c], c_p[0][c], e_res, e_p);
      end
      if (e_issue) begin
        checks++; if (c_a[0][c] !== 4'(c - 1) || c_x[0][c] !== 4'((c - 1) % 4)) begin
          failures++; $display("[TB] FAIL basic_addr c=%0d got=%0d/%0d exp=%0d/%0d",
                               c, c_a[0][c], c_x[0][c], c - 1, (c - 1) % 4);
        end
        checks++; if (c_ctl[0][c] !== ((c - 1) % 4 == 0)) begin
          failures++; $display("[TB] FAIL basic_control c=%0d got=%b exp=%b",
                               c, c_ctl[0][c], ((c - 1) % 4 == 0));
        end
      end
    end
  endtask

  task automatic test_stall();
    int k;
    int last;
    logic e_res, e_done, e_busy;
    logic [3:0] e_p;
    do_reset();
    clear_stim();
    st_start[0] = 1'b1;
    for (int c = 2; c <= 4; c++) st_stall[c] = 1'b1;
    run_capture(26);
    for (int c = 3; c <= 5; c++) begin
      checks++; if (c_issue[0][c] !== 1'b0) begin
        failures++; $display("[TB] FAIL stall_gap c=%0d got=%b exp=0", c, c_issue[0][c]);
      end
    end
    checks++; if (c_issue[0][6] !== 1'b1 || c_a[0][6] !== 4'd2) begin
      failures++; $display("[TB] FAIL stall_resume got=%b/%0d exp=1/2", c_issue[0][6], c_a[0][6]);
    end
    k = 0;
    last = 0;
    for (int c = 1; c <= 26; c++) begin
      if (c_issue[0][c] === 1'b1) begin
        checks++; if (c_a[0][c] !== 4'(k)) begin
          failures++; $display("[TB] FAIL stall_order c=%0d got=%0d exp=%0d", c, c_a[0][c], k);
        end
        k++;
        last = c;
      end
    end
    checks++; if (k != 16 || last != 19) begin
      failures++; $display("[TB] FAIL stall_count got=%0d@%0d exp=16@19", k, last);
    end
    for (int c = 1; c <= 26; c++) begin
      e_res  = (c == 9) || (c == 13) || (c == 17) || (c == 21);
      e_p    = e_res ? 4'((c - 9) / 4) : 4'd0;
      e_done = (c == 22);
      e_busy = (c <= 22);
      checks++; if (c_res[0][c] !== e_res || c_p[0][c] !== e_p) begin
        failures++; $display("[TB] FAIL stall_result c=%0d got=%b/%0d exp=%b/%0d",
                             c, c_res[0][c], c_p[0][c], e_res, e_p);
      end
      checks++; if (c_done[0][c] !== e_done || c_busy[0][c] !== e_busy) begin
        failures++; $display("[TB] FAIL stall_done c=%0d got=%b/%b exp=%b/%b",
                             c, c_done[0][c], c_busy[0][c], e_done, e_busy);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    clear_stim();
    st_start[0] = 1'b1;
    st_rst[8] = 1'b0;
    run_capture(20);
    checks++; if (c_issue[0][8] !== 1'b1 || c_a[0][8] !== 4'd7) begin
      failures++; $display("[TB] FAIL midrst_before got=%b/%0d exp=1/7", c_issue[0][8], c_a[0][8]);
    end
    for (int c = 9; c <= 20; c++) begin
      checks++; if ({c_issue[0][c], c_busy[0][c], c_done[0][c], c_res[0][c], c_ctl[0][c]} !== 5'b0
                    || c_a[0][c] !== 4'd0 || c_x[0][c] !== 4'd0 || c_p[0][c] !== 4'd0) begin
        failures++; $display("[TB] FAIL midrst_quiet c=%0d got=%b%b%b%b%b a=%0d x=%0d p=%0d exp=all0",
                             c, c_issue[0][c], c_busy[0][c], c_done[0][c], c_res[0][c], c_ctl[0][c],
                             c_a[0][c], c_x[0][c], c_p[0][c]);
      end
    end
    clear_stim();
    st_start[0] = 1'b1;
    run_capture(20);
    for (int c = 1; c <= 20; c++) begin
      checks++; if (c_issue[0][c] !== (c <= 16) || (c <= 16 && c_a[0][c] !== 4'(c - 1))) begin
        failures++; $display("[TB] FAIL midrst_rerun c=%0d got=%b/%0d exp=%b/%0d",
                             c, c_issue[0][c], c_a[0][c], (c <= 16), c - 1);
      end
    end
    checks++; if (c_res[0][6] !== 1'b1 || c_p[0][6] !== 4'd0 || c_done[0][19] !== 1'b1) begin
      failures++; $display("[TB] FAIL midrst_result got=%b/%0d/%b exp=1/0/1",
                           c_res[0][6], c_p[0][6], c_done[0][19]);
    end
  endtask

  task automatic test_start_ignored();
    int n_res;
    int n_done;
    do_reset();
    clear_stim();
    st_start[0] = 1'b1;
    st_start[2] = 1'b1;
    st_start[10] = 1'b1;
    run_capture(26);
    n_res = 0;
    n_done = 0;
    for (int c = 1; c <= 26; c++) begin
      if (c_res[0][c] === 1'b1) n_res++;
      if (c_done[0][c] === 1'b1) n_done++;
    end
    checks++; if (n_res != 4) begin
      failures++; $display("[TB] FAIL ignore_res_count got=%0d exp=4", n_res);
    end
    checks++; if (n_done != 1 || c_done[0][19] !== 1'b1) begin
      failures++; $display("[TB] FAIL ignore_done got=%0d/%b exp=1/1", n_done, c_done[0][19]);
    end
    checks++; if (c_a[0][11] !== 4'd10 || c_issue[0][11] !== 1'b1) begin
      failures++; $display("[TB] FAIL ignore_stream got=%b/%0d exp=1/10", c_issue[0][11], c_a[0][11]);
    end
    for (int c = 20; c <= 26; c++) begin
      checks++; if (c_busy[0][c] !== 1'b0 || c_issue[0][c] !== 1'b0) begin
        failures++; $display("[TB] FAIL ignore_idle c=%0d got=%b/%b exp=0/0", c, c_busy[0][c], c_issue[0][c]);
      end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    clear_stim();
    for (int c = 0; c <= 24; c++) st_start[c] = 1'b1;
    run_capture(24);
    checks++; if (c_busy[0][19] !== 1'b1 || c_done[0][19] !== 1'b1) begin
      failures++; $display("[TB] FAIL b2b_done got=%b/%b exp=1/1", c_busy[0][19], c_done[0][19]);
    end
    checks++; if (c_busy[0][20] !== 1'b0 || c_issue[0][20] !== 1'b0) begin
      failures++; $display("[TB] FAIL b2b_idle got=%b/%b exp=0/0", c_busy[0][20], c_issue[0][20]);
    end
    checks++; if (c_issue[0][21] !== 1'b1 || c_a[0][21] !== 4'd0 || c_ctl[0][21] !== 1'b1
                  || c_busy[0][21] !== 1'b1) begin
      failures++; $display("[TB] FAIL b2b_restart got=%b/%0d/%b/%b exp=1/0/1/1",
                           c_issue[0][21], c_a[0][21], c_ctl[0][21], c_busy[0][21]);
    end
    checks++; if (c_a[0][24] !== 4'd3 || c_x[0][24] !== 4'd3) begin
      failures++; $display("[TB] FAIL b2b_stream got=%0d/%0d exp=3/3", c_a[0][24], c_x[0][24]);
    end
  endtask

  task automatic test_cols1();
    logic e_issue, e_res;
    logic [3:0] e_p;
    do_reset();
    clear_stim();
    st_start[0] = 1'b1;
    run_capture(8);
    for (int c = 1; c <= 8; c++) begin
      e_issue = (c <= 3);
      e_res   = (c >= 2) && (c <= 4);
      e_p     = e_res ? 4'(c - 2) : 4'd0;
      checks++; if (c_issue[1][c] !== e_issue) begin
        failures++; $display("[TB] FAIL cols1_issue c=%0d got=%b exp=%b", c, c_issue[1][c], e_issue);
      end
      if (e_issue) begin
        checks++; if (c_ctl[1][c] !== 1'b1 || c_a[1][c] !== 4'(c - 1) || c_x[1][c] !== 4'd0) begin
          failures++; $display("[TB] FAIL cols1_elem c=%0d got=%b/%0d/%0d exp=1/%0d/0",
                               c, c_ctl[1][c], c_a[1][c], c_x[1][c], c - 1);
        end
      end
      checks++; if (c_res[1][c] !== e_res || c_p[1][c] !== e_p) begin
        failures++; $display("[TB] FAIL cols1_result c=%0d got=%b/%0d exp=%b/%0d",
                             c, c_res[1][c], c_p[1][c], e_res, e_p);
      end
      checks++; if (c_done[1][c] !== (c == 5) || c_busy[1][c] !== (c <= 5)) begin
        failures++; $display("[TB] FAIL cols1_done c=%0d got=%b/%b exp=%b/%b",
                             c, c_done[1][c], c_busy[1][c], (c == 5), (c <= 5));
      end
    end
  endtask

  task automatic test_rows2();
    logic e_issue, e_res;
    logic [3:0] e_p;
    do_reset();
    clear_stim();
    st_start[0] = 1'b1;
    run_capture(18);
    for (int c = 1; c <= 18; c++) begin
      e_issue = (c <= 10);
      e_res   = (c == 9) || (c == 14);
      e_p     = (c == 14) ? 4'd1 : 4'd0;
      checks++; if (c_issue[2][c] !== e_issue) begin
        failures++; $display("[TB] FAIL rows2_issue c=%0d got=%b exp=%b", c, c_issue[2][c], e_issue);
      end
      if (e_issue) begin
        checks++; if (c_a[2][c] !== 4'(c - 1) || c_x[2][c] !== 4'((c - 1) % 5)
                      || c_ctl[2][c] !== ((c - 1) % 5 == 0)) begin
          failures++; $display("[TB] FAIL rows2_elem c=%0d got=%0d/%0d/%b exp=%0d/%0d/%b",
                               c, c_a[2][c], c_x[2][c], c_ctl[2][c], c - 1, (c - 1) % 5,
                               ((c - 1) % 5 == 0));
        end
      end
      checks++; if (c_res[2][c] !== e_res || c_p[2][c] !== e_p) begin
        failures++; $display("[TB] FAIL rows2_result c=%0d got=%b/%0d exp=%b/%0d",
                             c, c_res[2][c], c_p[2][c], e_res, e_p);
      end
      checks++; if (c_done[2][c] !== (c == 15) || c_busy[2][c] !== (c <= 15)) begin
        failures++; $display("[TB] FAIL rows2_done c=%0d got=%b/%b exp=%b/%b",
                             c, c_done[2][c], c_busy[2][c], (c == 15), (c <= 15));
      end
    end
  endtask

  // Runs every scenario in turn and prints the overall tally.
  initial begin
    rst = 1'b0;
    start = 1'b0;
    stall = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_mid_reset();
    test_start_ignored();
    test_back_to_back();
    test_cols1();
    test_rows2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
